// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction in pipe1 into single-register load/store micro-ops, one per cycle.
// Latency: first micro-op 1 cycle after accept; k micro-ops for a k-bit mask (+1 base write-back when enabled).
// Backpressure: i_stall_in holds all state and outputs; o_stall_fetch freezes PC/pipe1 until the final micro-op is consumed.
//
// Optional feature macro: LMSM_BASE_WB_EN (adds a trailing base write-back micro-op, RA <= RA + count).
//
// Ports:
//   i_clk, i_reset        core clock, synchronous active-high reset
//   i_ir, i_ir_valid      instruction held in pipe1 and its valid flag
//   i_stall_in            downstream cannot accept a micro-op this cycle
//   i_flush               later stage redirected the PC; abandon the sequence
//   o_stall_fetch         hold PC and pipe1 (combinational)
//   o_busy                sequencer is expanding an instruction
//   o_uop_*               micro-op: valid, load(1)/store(0), reg, base, word offset, first, last, base write-back
module lm_sm_sequencer #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_ir,
    input  logic         i_ir_valid,
    input  logic         i_stall_in,
    input  logic         i_flush,
    output logic         o_stall_fetch,
    output logic         o_busy,
    output logic         o_uop_valid,
    output logic         o_uop_load,
    output logic [2:0]   o_uop_reg,
    output logic [2:0]   o_uop_base,
    output logic [W-1:0] o_uop_offset,
    output logic         o_uop_first,
    output logic         o_uop_last,
    output logic         o_uop_wb
);

    // Count must reach NREG so the write-back offset can equal the full transfer count.
    localparam int CW = $clog2(NREG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef LMSM_BASE_WB_EN
        S_WB   = 2'd2,
`endif
        S_SEQ  = 2'd1
    } state_t;

    state_t          r_state;
    logic [NREG-1:0] r_mask;
    logic [2:0]      r_base;
    logic [CW-1:0]   r_count;
    logic            r_load;

    logic            w_match;
    logic [NREG-1:0] w_new_mask;
    logic            w_accept;
    logic [2:0]      w_low_idx;
    logic            w_last_reg;
    logic            w_seq_last;
    logic            w_unused_ir8;

    // Opcodes 0110 (LM) and 0111 (SM) share ir[15:13]; ir[12] selects store.
    assign w_match      = i_ir_valid && (i_ir[15:13] == 3'b011);
    assign w_new_mask   = i_ir[NREG-1:0];
    assign w_accept     = (r_state == S_IDLE) && w_match && (|w_new_mask);
    assign w_unused_ir8 = i_ir[8];

    // Lowest set bit of the remaining mask: scanning downwards leaves the lowest index last.
    always_comb begin
        w_low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves zero.
    assign w_last_reg = (|r_mask) && ((r_mask & (r_mask - NREG'(1))) == '0);

`ifdef LMSM_BASE_WB_EN
    assign w_seq_last = 1'b0;
`else
    assign w_seq_last = w_last_reg;
`endif

    always_comb begin
        o_stall_fetch = 1'b0;
        o_busy        = 1'b0;
        o_uop_valid   = 1'b0;
        o_uop_load    = 1'b0;
        o_uop_reg     = '0;
        o_uop_base    = '0;
        o_uop_offset  = '0;
        o_uop_first   = 1'b0;
        o_uop_last    = 1'b0;
        o_uop_wb      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall_fetch = w_accept;
            end
            S_SEQ: begin
                o_busy        = 1'b1;
                o_uop_valid   = ~i_flush;
                o_uop_load    = r_load;
                o_uop_reg     = w_low_idx;
                o_uop_base    = r_base;
                o_uop_offset  = W'(r_count);
                o_uop_first   = (r_count == '0);
                o_uop_last    = w_seq_last;
                // Release pipe1 on the edge the final micro-op is consumed.
                o_stall_fetch = ~i_flush & ~(w_seq_last & ~i_stall_in);
            end
`ifdef LMSM_BASE_WB_EN
            S_WB: begin
                o_busy        = 1'b1;
                o_uop_valid   = ~i_flush;
                o_uop_load    = r_load;
                o_uop_reg     = r_base;
                o_uop_base    = r_base;
                o_uop_offset  = W'(r_count);
                o_uop_last    = 1'b1;
                o_uop_wb      = 1'b1;
                o_stall_fetch = ~i_flush & i_stall_in;
            end
`endif
            default: begin
                o_stall_fetch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_base  <= '0;
            r_count <= '0;
            r_load  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SEQ;
                        r_mask  <= w_new_mask;
                        r_base  <= i_ir[11:9];
                        r_load  <= ~i_ir[12];
                        r_count <= '0;
                    end
                end
                S_SEQ: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_mask  <= '0;
                    end else if (!i_stall_in) begin
                        r_mask  <= r_mask & (r_mask - NREG'(1));
                        r_count <= r_count + CW'(1);
                        if (w_last_reg) begin
`ifdef LMSM_BASE_WB_EN
                            r_state <= S_WB;
`else
                            r_state <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef LMSM_BASE_WB_EN
                S_WB: begin
                    if (i_flush || !i_stall_in) begin
                        r_state <= S_IDLE;
                        r_mask  <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed, table-driven bench for lm_sm_sequencer: one record per clock cycle.
// Inputs are driven 1 ns after the rising edge and outputs sampled 3 ns later.
// Hand-written sequences cover flush and mid-sequence reset.
module tb_lm_sm_sequencer;

`ifdef LMSM_BASE_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = '0;
    logic        ir_valid = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        stall_fetch, busy, uop_valid, uop_load, uop_first, uop_last, uop_wb;
    logic [2:0]  uop_reg, uop_base;
    logic [15:0] uop_offset;

    always #5 clk = ~clk;

    lm_sm_sequencer #(.NREG(8), .W(16)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ir          (ir),
        .i_ir_valid    (ir_valid),
        .i_stall_in    (stall_in),
        .i_flush       (flush),
        .o_stall_fetch (stall_fetch),
        .o_busy        (busy),
        .o_uop_valid   (uop_valid),
        .o_uop_load    (uop_load),
        .o_uop_reg     (uop_reg),
        .o_uop_base    (uop_base),
        .o_uop_offset  (uop_offset),
        .o_uop_first   (uop_first),
        .o_uop_last    (uop_last),
        .o_uop_wb      (uop_wb)
    );

    typedef struct packed {
        logic        sf;
        logic        bsy;
        logic        vld;
        logic        ld;
        logic [2:0]  rg;
        logic [2:0]  bs;
        logic [15:0] off;
        logic        fst;
        logic        lst;
        logic        wb;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] ir;
        logic        iv;
        logic        st;
        logic        fl;
        bit          chk;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic out_t mko(bit sf, bit bsy, bit vld, bit ld, int rg, int bs, int off,
                                 bit fst, bit lst, bit wb);
        out_t o;
        o.sf = sf; o.bsy = bsy; o.vld = vld; o.ld = ld;
        o.rg = 3'(rg); o.bs = 3'(bs); o.off = 16'(off);
        o.fst = fst; o.lst = lst; o.wb = wb;
        return o;
    endfunction

    // Accept cycle: only stall_fetch is high.
    function automatic out_t acc();
        return mko(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Register micro-op in SEQ.
    function automatic out_t uop(bit sf, bit vld, bit ld, int rg, int bs, int off, bit fst, bit lst);
        return mko(sf, 1, vld, ld, rg, bs, off, fst, lst, 0);
    endfunction

    // Base write-back micro-op.
    function automatic out_t wbop(bit ld, int rg, int off);
        return mko(0, 1, 1, ld, rg, rg, off, 0, 1, 1);
    endfunction

    function automatic vec_t mkv(string nm, logic rst, logic [15:0] irv, logic iv, logic st,
                                 logic fl, bit chk, out_t e);
        vec_t v;
        v.name = nm; v.rst = rst; v.ir = irv; v.iv = iv; v.st = st; v.fl = fl;
        v.chk = chk; v.exp = e;
        return v;
    endfunction

    function automatic string fmt(out_t x);
        return $sformatf("sf=%b busy=%b vld=%b ld=%b reg=%0d base=%0d off=%0d first=%b last=%b wb=%b",
                         x.sf, x.bsy, x.vld, x.ld, x.rg, x.bs, x.off, x.fst, x.lst, x.wb);
    endfunction

    task automatic apply(vec_t v);
        out_t act;
        reset    = v.rst;
        ir       = v.ir;
        ir_valid = v.iv;
        stall_in = v.st;
        flush    = v.fl;
        #3;
        if (v.chk) begin
            act.sf = stall_fetch; act.bsy = busy; act.vld = uop_valid; act.ld = uop_load;
            act.rg = uop_reg; act.bs = uop_base; act.off = uop_offset;
            act.fst = uop_first; act.lst = uop_last; act.wb = uop_wb;
            n_tot++;
            if (act === v.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %s ; expected %s", v.name, fmt(act), fmt(v.exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then reset state
        tbl.push_back(mkv("rst",       1, 16'h0000, 0, 0, 0, 0, '0));
        tbl.push_back(mkv("rst_state", 0, 16'h0000, 0, 0, 0, 1, '0));

        // LM R2, mask 0x25 -> R0, R2, R5; IR changes mid-sequence and must be ignored
        tbl.push_back(mkv("t1_acc",  0, 16'h6425, 1, 0, 0, 1, acc()));
        tbl.push_back(mkv("t1_u0",   0, 16'h6425, 1, 0, 0, 1, uop(1, 1, 1, 0, 2, 0, 1, 0)));
        tbl.push_back(mkv("t1_u1",   0, 16'h7E00, 1, 0, 0, 1, uop(1, 1, 1, 2, 2, 1, 0, 0)));
        tbl.push_back(mkv("t1_u2",   0, 16'h6425, 1, 0, 0, 1, uop(WB, 1, 1, 5, 2, 2, 0, !WB)));
`ifdef LMSM_BASE_WB_EN
        tbl.push_back(mkv("t1_wb",   0, 16'h1234, 1, 0, 0, 1, wbop(1, 2, 3)));
`endif
        tbl.push_back(mkv("t1_idle", 0, 16'h1234, 1, 0, 0, 1, '0));

        // SM R0, mask 0x81 with two stall cycles on the first micro-op
        tbl.push_back(mkv("t2_acc",    0, 16'h7081, 1, 0, 0, 1, acc()));
        tbl.push_back(mkv("t2_u0_st1", 0, 16'h7081, 1, 1, 0, 1, uop(1, 1, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv("t2_u0_st2", 0, 16'h7081, 1, 1, 0, 1, uop(1, 1, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv("t2_u0_go",  0, 16'h7081, 1, 0, 0, 1, uop(1, 1, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv("t2_u1",     0, 16'h7081, 1, 0, 0, 1, uop(WB, 1, 0, 7, 0, 1, 0, !WB)));
`ifdef LMSM_BASE_WB_EN
        tbl.push_back(mkv("t2_wb",     0, 16'h0000, 0, 0, 0, 1, wbop(0, 0, 2)));
`endif
        tbl.push_back(mkv("t2_idle",   0, 16'h0000, 0, 0, 0, 1, '0));

        // Zero mask with ir[8] set passes as NOP; non-valid LM is ignored
        tbl.push_back(mkv("t3_zero",      0, 16'h6100, 1, 0, 0, 1, '0));
        tbl.push_back(mkv("t3_zero_hold", 0, 16'h6100, 1, 0, 0, 1, '0));
        tbl.push_back(mkv("t3_novalid",   0, 16'h6425, 0, 0, 0, 1, '0));

        // Full mask LM R3: R0..R7 at offsets 0..7
        tbl.push_back(mkv("t4_acc", 0, 16'h66FF, 1, 0, 0, 1, acc()));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mkv($sformatf("t4_u%0d", i), 0, 16'h66FF, 1, 0, 0, 1,
                              uop(!((i == 7) && !WB), 1, 1, i, 3, i, i == 0, (i == 7) && !WB)));
        end
`ifdef LMSM_BASE_WB_EN
        tbl.push_back(mkv("t4_wb",   0, 16'h0000, 0, 0, 0, 1, wbop(1, 3, 8)));
`endif
        tbl.push_back(mkv("t4_idle", 0, 16'h0000, 0, 0, 0, 1, '0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
        end

        // Flush in IDLE is ignored; flush on 2nd micro-op abandons the sequence
        apply(mkv("t5_acc_fl", 0, 16'h6425, 1, 0, 1, 1, acc()));
        apply(mkv("t5_u0",     0, 16'h6425, 1, 0, 0, 1, uop(1, 1, 1, 0, 2, 0, 1, 0)));
        apply(mkv("t5_flush",  0, 16'h6425, 1, 0, 1, 1, mko(0, 1, 0, 1, 2, 2, 1, 0, 0, 0)));
        apply(mkv("t5_add",    0, 16'h1234, 1, 0, 0, 1, '0));
        apply(mkv("t5_add2",   0, 16'h1234, 1, 0, 0, 1, '0));

        // Reset in the middle of a full-mask LM, then a fresh LM
        apply(mkv("t6_acc", 0, 16'h66FF, 1, 0, 0, 1, acc()));
        for (int i = 0; i < 3; i++) begin
            apply(mkv($sformatf("t6_u%0d", i), 0, 16'h66FF, 1, 0, 0, 1,
                      uop(1, 1, 1, i, 3, i, i == 0, 0)));
        end
        apply(mkv("t6_rst",     1, 16'h66FF, 1, 0, 0, 1, uop(1, 1, 1, 3, 3, 3, 0, 0)));
        apply(mkv("t6_after",   0, 16'h0000, 0, 0, 0, 1, '0));
        apply(mkv("t6_acc2",    0, 16'h6425, 1, 0, 0, 1, acc()));
        apply(mkv("t6_n0",      0, 16'h6425, 1, 0, 0, 1, uop(1, 1, 1, 0, 2, 0, 1, 0)));
        apply(mkv("t6_n1",      0, 16'h6425, 1, 0, 0, 1, uop(1, 1, 1, 2, 2, 1, 0, 0)));
        apply(mkv("t6_n2",      0, 16'h6425, 1, 0, 0, 1, uop(WB, 1, 1, 5, 2, 2, 0, !WB)));
`ifdef LMSM_BASE_WB_EN
        apply(mkv("t6_nwb",     0, 16'h0000, 0, 0, 0, 1, wbop(1, 2, 3)));
`endif
        apply(mkv("t6_idle",    0, 16'h0000, 0, 0, 0, 1, '0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
